// File: rtl/pwm_rampa_motor.sv
// Soft-start motor PWM: ramps duty one point every PASO periods toward the sel_* target, with a fault lock-out.
// Optional FRENO_RAPIDO_EN: a drop to target 0 cuts duty to 0 at the next period end instead of ramping down.
module pwm_rampa_motor #(
  parameter int PRESC = 1,
  parameter int PASO  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_30,
  input  logic       sel_50,
  input  logic       sel_100,
  output logic       pwm_out,
  output logic [6:0] duty,
  output logic       en_rampa,
  output logic       falla
);

  localparam logic [2:0] REPOSO   = 3'd0;
  localparam logic [2:0] SUBIENDO = 3'd1;
  localparam logic [2:0] BAJANDO  = 3'd2;
  localparam logic [2:0] ESTABLE  = 3'd3;
  localparam logic [2:0] FALLA    = 3'd4;

  logic [15:0] pre;
  logic [6:0]  cnt;
  logic [7:0]  step;
  logic [6:0]  target;
  logic [2:0]  state;
  logic        ok_cnt;

  logic [1:0] n_hot;
  logic       multi;
  logic [6:0] sel_tgt;
  logic       tick, period_end, step_end;
  logic [2:0] cmp_state;

  assign n_hot   = 2'(sel_30) + 2'(sel_50) + 2'(sel_100);
  assign multi   = (n_hot > 2'd1);
  assign sel_tgt = sel_100 ? 7'd100 : sel_50 ? 7'd50 : sel_30 ? 7'd30 : 7'd0;

  assign tick       = (pre == 16'(PRESC - 1));
  assign period_end = tick && (cnt == 7'd99);
  assign step_end   = period_end && (step == 8'(PASO - 1));

  always_comb begin
    cmp_state = ESTABLE;
    if (duty < target)      cmp_state = SUBIENDO;
    else if (duty > target) cmp_state = BAJANDO;
    else if (target == 7'd0) cmp_state = REPOSO;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre    <= '0;
      cnt    <= '0;
      step   <= '0;
      target <= '0;
      duty   <= '0;
      state  <= REPOSO;
      ok_cnt <= 1'b0;
    end else begin
      pre <= tick ? 16'd0 : pre + 16'd1;
      if (tick) cnt <= (cnt == 7'd99) ? 7'd0 : cnt + 7'd1;
      // Step phase keeps running across target changes so reversals land on the same grid.
      if (period_end) step <= step_end ? 8'd0 : step + 8'd1;
      if (!multi) target <= sel_tgt;

      if (multi) begin
        state  <= FALLA;
        duty   <= '0;
        ok_cnt <= 1'b0;
      end else if (state == FALLA) begin
        duty <= '0;
        if (ok_cnt) begin
          state  <= REPOSO;
          ok_cnt <= 1'b0;
        end else begin
          ok_cnt <= 1'b1;
        end
      end else begin
`ifdef FRENO_RAPIDO_EN
        if (target == 7'd0) begin
          if (period_end) duty <= '0;
          state <= REPOSO;
        end else begin
          if (step_end) begin
            if (duty < target && duty < 7'd100) duty <= duty + 7'd1;
            else if (duty > target && duty != 7'd0) duty <= duty - 7'd1;
          end
          state <= cmp_state;
        end
`else
        if (step_end) begin
          if (duty < target && duty < 7'd100) duty <= duty + 7'd1;
          else if (duty > target && duty != 7'd0) duty <= duty - 7'd1;
        end
        state <= cmp_state;
`endif
      end
    end
  end

  // duty only changes together with the 99->0 wrap, so each period sees one duty value.
  assign pwm_out  = (cnt < duty) && (state != FALLA);
  assign en_rampa = (state == SUBIENDO) || (state == BAJANDO);
  assign falla    = (state == FALLA);

endmodule

// File: tb/tb_pwm_rampa_motor.sv
// Directed bench: instance a (PRESC=1, PASO=1) covers ramp, reversal, fault, release and reset;
// instance b (PRESC=3, PASO=2) runs the slow ramp to 100 in parallel.
module tb_pwm_rampa_motor;
  logic clk = 1'b0;
  logic reset = 1'b1, reset_b = 1'b1;
  logic a30 = 0, a50 = 0, a100 = 0;
  logic b30 = 0, b50 = 0, b100 = 0;
  logic pwm_a, en_a, falla_a, pwm_b, en_b, falla_b;
  logic [6:0] duty_a, duty_b;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pwm_rampa_motor #(.PRESC(1), .PASO(1)) dut_a (
    .clk(clk), .reset(reset), .sel_30(a30), .sel_50(a50), .sel_100(a100),
    .pwm_out(pwm_a), .duty(duty_a), .en_rampa(en_a), .falla(falla_a));

  pwm_rampa_motor #(.PRESC(3), .PASO(2)) dut_b (
    .clk(clk), .reset(reset_b), .sel_30(b30), .sel_50(b50), .sel_100(b100),
    .pwm_out(pwm_b), .duty(duty_b), .en_rampa(en_b), .falla(falla_b));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_a(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_duty_a(input string tag, input int v, input int budget);
    int n = 0;
    while (int'(duty_a) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(duty_a), v);
  endtask

  initial begin
    fork
      begin : seq_a
        int hi, mx;
        wait_a(3);
        chk("rst_duty", duty_a, 0);
        chk("rst_pwm", pwm_a, 0);
        chk("rst_en", en_a, 0);
        chk("rst_falla", falla_a, 0);
        // ramp up to 30
        reset = 0; a30 = 1;
        wait_a(99);   chk("up_99", duty_a, 0);
        chk("up_en", en_a, 1);
        wait_a(1);    chk("up_100", duty_a, 1);
        wait_a(2899); chk("up_2999", duty_a, 29);
        wait_a(1);    chk("up_3000", duty_a, 30);
        wait_a(5);    chk("up_en_low", en_a, 0);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (pwm_a) hi++;
        end
        chk("pwm30_high", hi, 30);
        // reversal at 60
        a30 = 0; a100 = 1;
        wait_duty_a("rev_reach60", 60, 4000);
        a100 = 0; a50 = 1;
        mx = 0;
        for (int i = 1; i <= 1000; i++) begin
          @(negedge clk);
          if (int'(duty_a) > mx) mx = int'(duty_a);
          if (i == 99)  chk("rev_99", duty_a, 60);
          if (i == 100) chk("rev_100", duty_a, 59);
        end
        chk("rev_1000", duty_a, 50);
        chk("rev_max", mx, 60);
        wait_a(5);    chk("rev_en_low", en_a, 0);
        // fault
        a30 = 1; a100 = 1; a50 = 0;
        wait_a(1);
        chk("flt_falla", falla_a, 1);
        chk("flt_pwm", pwm_a, 0);
        chk("flt_duty", duty_a, 0);
        a30 = 0; a100 = 0; a50 = 1;
        wait_a(1);    chk("flt_hold", falla_a, 1);
        wait_a(1);    chk("flt_exit", falla_a, 0);
        chk("flt_exit_duty", duty_a, 0);
        wait_duty_a("flt_ramp1", 1, 200);
        // release to idle from 30
        a50 = 0; a30 = 1;
        wait_duty_a("rel_reach30", 30, 3500);
        a30 = 0;
`ifdef FRENO_RAPIDO_EN
        wait_a(50);   chk("rel_en", en_a, 0);
        wait_a(49);   chk("rel_99", duty_a, 30);
        wait_a(1);    chk("rel_100", duty_a, 0);
        wait_a(5);    chk("rel_en_end", en_a, 0);
`else
        wait_a(50);   chk("rel_en", en_a, 1);
        wait_a(50);   chk("rel_100", duty_a, 29);
        wait_a(2850); chk("rel_2950", duty_a, 1);
        chk("rel_en_late", en_a, 1);
        wait_a(50);   chk("rel_3000", duty_a, 0);
        wait_a(5);    chk("rel_en_end", en_a, 0);
`endif
        // reset mid-ramp
        a50 = 1;
        wait_duty_a("rst_reach17", 17, 2000);
        wait_a(30);
        reset = 1;
        #1;
        chk("arst_duty", duty_a, 0);
        chk("arst_pwm", pwm_a, 0);
        chk("arst_en", en_a, 0);
        chk("arst_falla", falla_a, 0);
        wait_a(2);
        reset = 0;
        wait_a(99);   chk("rr_99", duty_a, 0);
        wait_a(1);    chk("rr_100", duty_a, 1);
        wait_a(100);  chk("rr_200", duty_a, 2);
      end
      begin : seq_b
        int hi;
        repeat (3) @(negedge clk);
        chk("b_rst_duty", duty_b, 0);
        chk("b_rst_pwm", pwm_b, 0);
        reset_b = 0; b100 = 1;
        repeat (599) @(negedge clk);
        chk("b_599", duty_b, 0);
        repeat (1) @(negedge clk);
        chk("b_600", duty_b, 1);
        repeat (59399) @(negedge clk);
        chk("b_59999", duty_b, 99);
        repeat (1) @(negedge clk);
        chk("b_60000", duty_b, 100);
        hi = 0;
        for (int i = 0; i < 1200; i++) begin
          @(negedge clk);
          if (pwm_b) hi++;
        end
        chk("b_pwm_const", hi, 1200);
        chk("b_nowrap", duty_b, 100);
        chk("b_en_low", en_b, 0);
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
